systolic_skew_feeder: RTL and testbench
=======================================

// Module: systolic_skew_feeder
// PURPOSE
// - Upstream feeder for the TILE x TILE n-body systolic array.
// - Buffers one frame of N_BODIES (position, mass) records.
// - Walks the block schedule (I,J) and drives the array's row (i) and column (j) edges.
// - Edge element k is delayed k cycles so that wavefronts meet correctly in the registered cells.
// - Data is signed fixed point and passes through untouched; this block does no arithmetic.
// PARAMETERS
// - N_BODIES  4   bodies per frame; must be a multiple of TILE
// - TILE      2   array edge length
// - Q_W       32  position word width (signed)
// - M_W       32  mass word width (unsigned)
// - NB = N_BODIES/TILE (derived); BI_W = max(1, $clog2(NB)) (derived)
// PORTS
// - clk        in   1          clock, rising edge
// - rst        in   1          synchronous, active-high reset
// - in_valid   in   1          body record valid
// - in_ready   out  1          feeder accepts a record
// - in_q       in   Q_W        body position
// - in_m       in   M_W        body mass
// - start      in   1          begin issuing the loaded frame
// - hold       in   1          array back-pressure; freezes ISSUE/FLUSH
// - row_q      out  TILE*Q_W   row-edge positions; row r at [r*Q_W +: Q_W]
// - row_m      out  TILE*M_W   row-edge masses
// - row_valid  out  TILE       row r data valid
// - col_q      out  TILE*Q_W   column-edge positions; column c at [c*Q_W +: Q_W]
// - col_m      out  TILE*M_W   column-edge masses
// - col_valid  out  TILE       column c data valid
// - blk_i      out  BI_W       row-block index of the element-0 wavefront
// - blk_j      out  BI_W       column-block index of the element-0 wavefront
// - blk_diag   out  1          blk_i == blk_j (array must mask self-interaction)
// - busy       out  1          state is ISSUE or FLUSH
// - done       out  1          one-cycle pulse at end of frame
// BEHAVIOUR
// - Reset: all outputs 0 (in_ready 0 while rst high); state IDLE; body count 0.
//   Any mid-run reset aborts the frame; all valids are 0 on the first cycle after rst.
// - FSM:
//   - IDLE: in_ready = 1; body k = k-th accept (in_valid & in_ready) is written to buffer[k].
//     On accept N_BODIES-1 go to LOADED.
//   - LOADED: in_ready = 0; in_valid ignored.
//     start & !hold moves to ISSUE; start in any other state is ignored.
//   - ISSUE: one schedule step per cycle in which hold = 0.
//     Step sends q/m of bodies I*TILE+r to row r and J*TILE+c to column c into the skew chains.
//     After the last block go to FLUSH.
//   - FLUSH: TILE-1 unheld cycles drain the skew chains, then go to DONE.
//   - DONE: done = 1 for one cycle, then IDLE with body count 0. The buffer must be reloaded for each frame.
// - Schedule: upper triangle, row-major: (0,0),(0,1)..(0,NB-1),(1,1)..(NB-1,NB-1).
//   Step count is NB*(NB+1)/2.
// - Skew: row r and column c outputs pass through r (resp. c) extra registers.
//   - The valid bit travels with the data; element 0 is registered once.
//   - Start accepted at cycle 0: row0/col0 are valid at cycles 1..S, row r at cycles 1+r..S+r (S = step count).
//   - done is high at cycle S+TILE.
// - hold = 1: no state, counter or skew-register change; all outputs stable. Applies in every state except IDLE loading.
// - blk_i/blk_j/blk_diag are aligned with element 0 (row0/col0) and hold their last value after the frame ends.
// - Data bits are don't-care while the matching valid is 0, but are required to be stable, not X.
// CONFIGURATION
// - FEEDER_FULL_MATRIX_EN defined: issue all NB*NB blocks row-major (0,0),(0,1)..(NB-1,NB-1), S = NB*NB.
//   Used for arrays without the antisymmetric p_down return path.
// - Not defined: upper-triangle schedule as above.
// TESTING
// - N=4, TILE=2: load q={1,2,3,4}, m={10,20,30,40}, pulse start.
//   - Row0 valid cycles 1-3: q=1,1,3. Row1 valid cycles 2-4: q=2,2,4. Col1 valid cycles 2-4: q=2,4,4.
//   - blk (i,j) = (0,0),(0,1),(1,1); done at cycle 5.
// - start pulsed in IDLE after 2 of 4 loads -> ignored; in_ready stays 1; no valids.
// - hold=1 on cycle 2 of ISSUE for 3 cycles -> outputs frozen; sequence resumes unchanged; done is 3 cycles late.
// - rst asserted on cycle 2 of ISSUE -> next cycle all valids 0, busy 0, in_ready 1; a full reload and start reproduce test 1.
// - in_valid held high for 6 cycles in IDLE -> exactly 4 accepted; records 5 and 6 get in_ready 0 and are not stored.
// - FEEDER_FULL_MATRIX_EN, same load as test 1 -> 4 blocks (0,0),(0,1),(1,0),(1,1); done at cycle 6.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Frame buffer and block-schedule walker that feeds the edges of a TILE x TILE n-body array.
// Define FEEDER_FULL_MATRIX_EN to issue all NB*NB blocks instead of the upper triangle.
module systolic_skew_feeder #(
    parameter int N_BODIES = 4,
    parameter int TILE     = 2,
    parameter int Q_W      = 32,
    parameter int M_W      = 32,
    localparam int NB      = N_BODIES / TILE,
    localparam int BI_W    = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [Q_W-1:0]        in_q,
    input  logic [M_W-1:0]        in_m,
    input  logic                  start,
    input  logic                  hold,
    output logic [TILE*Q_W-1:0]   row_q,
    output logic [TILE*M_W-1:0]   row_m,
    output logic [TILE-1:0]       row_valid,
    output logic [TILE*Q_W-1:0]   col_q,
    output logic [TILE*M_W-1:0]   col_m,
    output logic [TILE-1:0]       col_valid,
    output logic [BI_W-1:0]       blk_i,
    output logic [BI_W-1:0]       blk_j,
    output logic                  blk_diag,
    output logic                  busy,
    output logic                  done
);
    localparam int IDX_W = (N_BODIES > 1) ? $clog2(N_BODIES) : 1;
    localparam int CNT_W = $clog2(N_BODIES + 1);
    localparam int FL_W  = (TILE > 1) ? $clog2(TILE) : 1;
    localparam int E_W   = 1 + M_W + Q_W;
    localparam logic [BI_W-1:0]  BLK_LAST = BI_W'(NB - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BODIES - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'((TILE > 1) ? TILE - 2 : 0);

    typedef enum logic [2:0] {S_IDLE, S_LOADED, S_ISSUE, S_FLUSH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BI_W-1:0]   bi_q, bi_d, bj_q, bj_d;
    logic [BI_W-1:0]   blk_i_q, blk_i_d, blk_j_q, blk_j_d;
    logic              diag_q, diag_d;
    logic [FL_W-1:0]   fl_q, fl_d;
    logic              done_q, done_d;

    logic [Q_W-1:0]    q_mem [N_BODIES];
    logic [M_W-1:0]    m_mem [N_BODIES];

    logic accept, issue_step, last_blk;

    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign issue_step = (state_q == S_ISSUE) && !hold;
    assign last_blk   = (bi_q == BLK_LAST) && (bj_q == BLK_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bi_d    = bi_q;
        bj_d    = bj_q;
        blk_i_d = blk_i_q;
        blk_j_d = blk_j_q;
        diag_d  = diag_q;
        fl_d    = fl_q;
        done_d  = hold ? done_q : (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = S_LOADED;
                end
            end
            S_LOADED: begin
                if (start && !hold) begin
                    state_d = S_ISSUE;
                    bi_d    = '0;
                    bj_d    = '0;
                end
            end
            S_ISSUE: begin
                if (!hold) begin
                    // Block index registers travel with element 0 of the skew chains.
                    blk_i_d = bi_q;
                    blk_j_d = bj_q;
                    diag_d  = (bi_q == bj_q);
                    if (last_blk) begin
                        state_d = (TILE > 1) ? S_FLUSH : S_DONE;
                        fl_d    = '0;
                    end else if (bj_q == BLK_LAST) begin
                        bi_d = bi_q + 1'b1;
`ifdef FEEDER_FULL_MATRIX_EN
                        bj_d = '0;
`else
                        bj_d = bi_q + 1'b1;
`endif
                    end else begin
                        bj_d = bj_q + 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (!hold) begin
                    if (fl_q == FL_LAST) state_d = S_DONE;
                    else                 fl_d    = fl_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!hold) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bi_q    <= '0;
            bj_q    <= '0;
            blk_i_q <= '0;
            blk_j_q <= '0;
            diag_q  <= 1'b0;
            fl_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bi_q    <= bi_d;
            bj_q    <= bj_d;
            blk_i_q <= blk_i_d;
            blk_j_q <= blk_j_d;
            diag_q  <= diag_d;
            fl_q    <= fl_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_mem[cnt_q[IDX_W-1:0]] <= in_q;
            m_mem[cnt_q[IDX_W-1:0]] <= in_m;
        end
    end

    // Lane gi owns a gi+1 deep chain of {valid, m, q} words; zeros are fed when not issuing.
    for (genvar gi = 0; gi < TILE; gi++) begin : g_lane
        logic [IDX_W-1:0] row_idx, col_idx;
        logic [E_W-1:0]   row_pipe_q [0:gi];
        logic [E_W-1:0]   row_pipe_d [0:gi];
        logic [E_W-1:0]   col_pipe_q [0:gi];
        logic [E_W-1:0]   col_pipe_d [0:gi];

        assign row_idx = IDX_W'(bi_q) * IDX_W'(TILE) + IDX_W'(gi);
        assign col_idx = IDX_W'(bj_q) * IDX_W'(TILE) + IDX_W'(gi);

        always_comb begin
            row_pipe_d = row_pipe_q;
            col_pipe_d = col_pipe_q;
            if (!hold) begin
                row_pipe_d[0] = issue_step ? {1'b1, m_mem[row_idx], q_mem[row_idx]} : '0;
                col_pipe_d[0] = issue_step ? {1'b1, m_mem[col_idx], q_mem[col_idx]} : '0;
                for (int s = 1; s <= gi; s++) begin
                    row_pipe_d[s] = row_pipe_q[s-1];
                    col_pipe_d[s] = col_pipe_q[s-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s <= gi; s++) begin
                    row_pipe_q[s] <= '0;
                    col_pipe_q[s] <= '0;
                end
            end else begin
                row_pipe_q <= row_pipe_d;
                col_pipe_q <= col_pipe_d;
            end
        end

        assign row_q[gi*Q_W +: Q_W] = row_pipe_q[gi][Q_W-1:0];
        assign row_m[gi*M_W +: M_W] = row_pipe_q[gi][Q_W +: M_W];
        assign row_valid[gi]        = row_pipe_q[gi][E_W-1];
        assign col_q[gi*Q_W +: Q_W] = col_pipe_q[gi][Q_W-1:0];
        assign col_m[gi*M_W +: M_W] = col_pipe_q[gi][Q_W +: M_W];
        assign col_valid[gi]        = col_pipe_q[gi][E_W-1];
    end

    assign blk_i    = blk_i_q;
    assign blk_j    = blk_j_q;
    assign blk_diag = diag_q;
    assign busy     = (state_q == S_ISSUE) || (state_q == S_FLUSH);
    assign done     = done_q;
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder, N_BODIES=4, TILE=2; expected tables are hand-derived.
module tb_systolic_skew_feeder;
    localparam int N = 4;
    localparam int T = 2;
    localparam int QW = 32;
    localparam int MW = 32;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, start, hold;
    logic [QW-1:0] in_q;
    logic [MW-1:0] in_m;
    logic [T*QW-1:0] row_q, col_q;
    logic [T*MW-1:0] row_m, col_m;
    logic [T-1:0]  row_valid, col_valid;
    logic          blk_i, blk_j, blk_diag, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    int e_rv[16], e_cv[16], e_r0q[16], e_r1q[16], e_c0q[16], e_c1q[16];
    int e_bi[16], e_bj[16], e_dg[16], e_done[16], e_busy[16];

    systolic_skew_feeder #(.N_BODIES(N), .TILE(T), .Q_W(QW), .M_W(MW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_q(in_q), .in_m(in_m), .start(start), .hold(hold),
        .row_q(row_q), .row_m(row_m), .row_valid(row_valid),
        .col_q(col_q), .col_m(col_m), .col_valid(col_valid),
        .blk_i(blk_i), .blk_j(blk_j), .blk_diag(blk_diag),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            in_valid = 1'b1;
            in_q     = QW'(k + 1);
            in_m     = MW'(10 * (k + 1));
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Expects LOADED at a negedge; hold is raised on cycles hs..hs+hl-1.
    task automatic run_frame(input string name, input int hs, input int hl);
        int  e;
        logic held;
        e = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check({name, ".row_valid"}, 64'(row_valid), 64'(e_rv[e]));
            check({name, ".col_valid"}, 64'(col_valid), 64'(e_cv[e]));
            check({name, ".done"}, 64'(done), 64'(e_done[e]));
            check({name, ".busy"}, 64'(busy), 64'(e_busy[e]));
            if (row_valid[0]) begin
                check({name, ".row0_q"}, 64'(row_q[QW-1:0]), 64'(e_r0q[e]));
                check({name, ".row0_m"}, 64'(row_m[MW-1:0]), 64'(10 * e_r0q[e]));
            end
            if (row_valid[1]) check({name, ".row1_q"}, 64'(row_q[QW +: QW]), 64'(e_r1q[e]));
            if (col_valid[0]) check({name, ".col0_q"}, 64'(col_q[QW-1:0]), 64'(e_c0q[e]));
            if (col_valid[1]) begin
                check({name, ".col1_q"}, 64'(col_q[QW +: QW]), 64'(e_c1q[e]));
                check({name, ".col1_m"}, 64'(col_m[MW +: MW]), 64'(10 * e_c1q[e]));
            end
            if (e >= 1) begin
                check({name, ".blk_i"}, 64'(blk_i), 64'(e_bi[e]));
                check({name, ".blk_j"}, 64'(blk_j), 64'(e_bj[e]));
                check({name, ".blk_diag"}, 64'(blk_diag), 64'(e_dg[e]));
            end
            held = (k >= hs) && (k < hs + hl);
            hold = held;
            @(negedge clk);
            if (!held) e++;
        end
        hold = 1'b0;
        $display("frame %s: cycles checked, compared=%0d mismatched=%0d", name, n_cmp, n_bad);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            e_rv[i] = 0; e_cv[i] = 0; e_r0q[i] = 0; e_r1q[i] = 0; e_c0q[i] = 0; e_c1q[i] = 0;
            e_bi[i] = 1; e_bj[i] = 1; e_dg[i] = 1; e_done[i] = 0; e_busy[i] = 0;
        end
`ifdef FEEDER_FULL_MATRIX_EN
        e_rv[1] = 1; e_rv[2] = 3; e_rv[3] = 3; e_rv[4] = 3; e_rv[5] = 2;
        e_r0q[1] = 1; e_r0q[2] = 1; e_r0q[3] = 3; e_r0q[4] = 3;
        e_r1q[2] = 2; e_r1q[3] = 2; e_r1q[4] = 4; e_r1q[5] = 4;
        e_c0q[1] = 1; e_c0q[2] = 3; e_c0q[3] = 1; e_c0q[4] = 3;
        e_c1q[2] = 2; e_c1q[3] = 4; e_c1q[4] = 2; e_c1q[5] = 4;
        e_bi[1] = 0; e_bi[2] = 0; e_bi[3] = 1; e_bi[4] = 1;
        e_bj[1] = 0; e_bj[2] = 1; e_bj[3] = 0; e_bj[4] = 1;
        e_dg[1] = 1; e_dg[2] = 0; e_dg[3] = 0; e_dg[4] = 1;
        e_done[6] = 1;
        for (int i = 0; i <= 4; i++) e_busy[i] = 1;
`else
        e_rv[1] = 1; e_rv[2] = 3; e_rv[3] = 3; e_rv[4] = 2;
        e_r0q[1] = 1; e_r0q[2] = 1; e_r0q[3] = 3;
        e_r1q[2] = 2; e_r1q[3] = 2; e_r1q[4] = 4;
        e_c0q[1] = 1; e_c0q[2] = 3; e_c0q[3] = 3;
        e_c1q[2] = 2; e_c1q[3] = 4; e_c1q[4] = 4;
        e_bi[1] = 0; e_bi[2] = 0; e_bi[3] = 1;
        e_bj[1] = 0; e_bj[2] = 1; e_bj[3] = 1;
        e_dg[1] = 1; e_dg[2] = 0; e_dg[3] = 1;
        e_done[5] = 1;
        for (int i = 0; i <= 3; i++) e_busy[i] = 1;
`endif
        for (int i = 0; i < 16; i++) e_cv[i] = e_rv[i];

        rst = 1'b1; in_valid = 1'b0; in_q = '0; in_m = '0; start = 1'b0; hold = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.in_ready", 64'(in_ready), 64'd0);
        check("rst.row_valid", 64'(row_valid), 64'd0);
        check("rst.col_valid", 64'(col_valid), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.blk_i", 64'(blk_i), 64'd0);
        check("rst.blk_diag", 64'(blk_diag), 64'd0);
        rst = 1'b0;
        #1;
        check("idle.in_ready", 64'(in_ready), 64'd1);

        load(0, 4);
        check("loaded.in_ready", 64'(in_ready), 64'd0);
        run_frame("basic", -1, 0);

        load(0, 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("early_start.in_ready", 64'(in_ready), 64'd1);
            check("early_start.row_valid", 64'(row_valid), 64'd0);
            check("early_start.busy", 64'(busy), 64'd0);
            @(negedge clk);
        end
        load(2, 4);
        check("early_start.loaded", 64'(in_ready), 64'd0);
        run_frame("early_start", -1, 0);

        load(0, 4);
        run_frame("hold", 2, 3);

        load(0, 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort.row_valid", 64'(row_valid), 64'd0);
        check("abort.col_valid", 64'(col_valid), 64'd0);
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        load(0, 4);
        run_frame("after_abort", -1, 0);

        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_q     = QW'(k + 1);
            in_m     = MW'(10 * (k + 1));
            #1;
            check("overrun.in_ready", 64'(in_ready), (k < 4) ? 64'd1 : 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        run_frame("overrun", -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
